// File: rtl/downsample.sv
// 2x2 pooling (max / min / average) as a two-stage pipeline with a global stall.
// Optional argmax output enabled by defining DOWNSAMPLE_ARGMAX_EN.
module downsample #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_00,
  input  logic [DATA_W-1:0] pixel_01,
  input  logic [DATA_W-1:0] pixel_10,
  input  logic [DATA_W-1:0] pixel_11,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] max_pixel,
  output logic              out_valid,
  input  logic              out_ready
`ifdef DOWNSAMPLE_ARGMAX_EN
  ,
  output logic [1:0]        max_idx
`endif
);

  localparam int unsigned RSUM_W = DATA_W + 1;
  localparam int unsigned TSUM_W = DATA_W + 2;

  typedef enum logic [1:0] {
    OP_MAX = 2'd0,
    OP_MIN = 2'd1,
    OP_AVG = 2'd2
  } op_e;

  // Strictly-better test: a tie keeps the incumbent, which always has the lower index.
  function automatic logic beats(input logic [DATA_W-1:0] cand,
                                 input logic [DATA_W-1:0] inc,
                                 input op_e op);
    return (op == OP_MIN) ? (cand < inc) : (cand > inc);
  endfunction

  logic              advance;
  op_e               op_in;

  logic              s1_valid_q;
  op_e               s1_op_q,  s1_op_d;
  logic [DATA_W-1:0] r0_val_q, r0_val_d, r1_val_q, r1_val_d;
  logic [RSUM_W-1:0] r0_sum_q, r0_sum_d, r1_sum_q, r1_sum_d;
  logic              r0_pick,  r1_pick,  row_pick;

  logic              out_valid_q;
  logic [DATA_W-1:0] pix_q,    pix_d;
  logic [TSUM_W-1:0] tot_sum;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign max_pixel = pix_q;

  // Stage 1: per-row reduction
  always_comb begin
    case (mode)
      2'b01:   op_in = OP_MIN;
      2'b10:   op_in = OP_AVG;
      default: op_in = OP_MAX;
    endcase
    s1_op_d  = op_in;
    r0_pick  = beats(pixel_01, pixel_00, op_in);
    r1_pick  = beats(pixel_11, pixel_10, op_in);
    r0_val_d = r0_pick ? pixel_01 : pixel_00;
    r1_val_d = r1_pick ? pixel_11 : pixel_10;
    r0_sum_d = RSUM_W'(pixel_00) + RSUM_W'(pixel_01);
    r1_sum_d = RSUM_W'(pixel_10) + RSUM_W'(pixel_11);
  end

  // Stage 2: combine rows
  always_comb begin
    row_pick = beats(r1_val_q, r0_val_q, s1_op_q);
    tot_sum  = TSUM_W'(r0_sum_q) + TSUM_W'(r1_sum_q);
    if (s1_op_q == OP_AVG) pix_d = tot_sum[TSUM_W-1:2];
    else                   pix_d = row_pick ? r1_val_q : r0_val_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_MAX;
      r0_val_q    <= '0;
      r1_val_q    <= '0;
      r0_sum_q    <= '0;
      r1_sum_q    <= '0;
      out_valid_q <= 1'b0;
      pix_q       <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s1_op_q     <= s1_op_d;
      r0_val_q    <= r0_val_d;
      r1_val_q    <= r1_val_d;
      r0_sum_q    <= r0_sum_d;
      r1_sum_q    <= r1_sum_d;
      out_valid_q <= s1_valid_q;
      pix_q       <= pix_d;
    end
  end

`ifdef DOWNSAMPLE_ARGMAX_EN
  logic       r0_col_q, r1_col_q;
  logic [1:0] idx_q,    idx_d;

  always_comb begin
    if (s1_op_q == OP_AVG) idx_d = 2'd0;
    else                   idx_d = {row_pick, row_pick ? r1_col_q : r0_col_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_col_q <= 1'b0;
      r1_col_q <= 1'b0;
      idx_q    <= '0;
    end else if (advance) begin
      r0_col_q <= r0_pick;
      r1_col_q <= r1_pick;
      idx_q    <= idx_d;
    end
  end

  assign max_idx = idx_q;
`endif

endmodule

// File: tb/tb_downsample.sv
// Randomized and directed bench for downsample, checked against a per-window reference model.
module tb_downsample;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p00, p01, p10, p11;
  logic [1:0]    mode;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] max_pixel;
  logic [1:0]    max_idx;

  always #5 clk = ~clk;

  downsample #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .pixel_00(p00), .pixel_01(p01), .pixel_10(p10), .pixel_11(p11),
    .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .max_pixel(max_pixel), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DOWNSAMPLE_ARGMAX_EN
    , .max_idx(max_idx)
`endif
  );

`ifndef DOWNSAMPLE_ARGMAX_EN
  assign max_idx = 2'd0;
`endif

  typedef struct packed {
    logic [1:0]          m;
    logic [3:0][DW-1:0]  p;
  } win_t;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic [1:0]    idx;
    int            acc;
    int            stalls;
  } exp_t;

  win_t pend[$];
  exp_t expq[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, stalls = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_pix;
  logic [1:0]    prev_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic win_t mk(input logic [1:0] m, input int a, input int b, input int c, input int d);
    win_t w;
    w.m = m;
    w.p[0] = DW'(a); w.p[1] = DW'(b); w.p[2] = DW'(c); w.p[3] = DW'(d);
    return w;
  endfunction

  // Pooling straight from the definition: scan positions in order, replace only on strict improvement.
  function automatic exp_t ref_model(input win_t w);
    exp_t e;
    int   s, best;
    s = 0; best = 0;
    for (int i = 0; i < 4; i++) s += int'(w.p[i]);
    e = '0;
    if (w.m == 2'b10) begin
      e.pix = DW'(s / 4);
      e.idx = 2'd0;
    end else begin
      for (int i = 1; i < 4; i++)
        if ((w.m == 2'b01) ? (w.p[i] < w.p[best]) : (w.p[i] > w.p[best])) best = i;
      e.pix = w.p[best];
      e.idx = 2'(best);
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] rpix();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return DW'($urandom);
    endcase
  endfunction

  task automatic step(input logic ordy, input logic rand_in);
    win_t w;
    logic v;
    exp_t e;
    @(negedge clk);
    if (pend.size() > 0) begin
      w = pend[0]; v = 1'b1;
    end else if (rand_in) begin
      w.m = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) w.p[i] = rpix();
      v = ($urandom_range(0, 3) != 0);
    end else begin
      w = '0; v = 1'b0;
    end
    p00 = w.p[0]; p01 = w.p[1]; p10 = w.p[2]; p11 = w.p[3];
    mode = w.m; in_valid = v; out_ready = ordy;
    #1;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_pixel", 32'(max_pixel), 32'(prev_pix));
`ifdef DOWNSAMPLE_ARGMAX_EN
      check("hold_idx", 32'(max_idx), 32'(prev_idx));
`endif
    end
    if (out_valid && !out_ready) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      stalls++;
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("spurious_output", 32'(out_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        check("pixel", 32'(max_pixel), 32'(e.pix));
`ifdef DOWNSAMPLE_ARGMAX_EN
        check("idx", 32'(max_idx), 32'(e.idx));
`endif
        if (e.stalls == stalls) check("latency", 32'(cyc - e.acc), 32'd2);
      end
    end
    if (v && in_ready) begin
      e = ref_model(w);
      e.acc = cyc; e.stalls = stalls;
      expq.push_back(e);
      if (pend.size() > 0) void'(pend.pop_front());
    end
    prev_stall = out_valid && !out_ready;
    prev_pix   = max_pixel;
    prev_idx   = max_idx;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; mode = 2'b00;
    p00 = 8'd200; p01 = 8'd201; p10 = 8'd202; p11 = 8'd203;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    expq.delete();
    pend.delete();
    prev_stall = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pixel", 32'(max_pixel), 32'd0);
`ifdef DOWNSAMPLE_ARGMAX_EN
    check("rst_idx", 32'(max_idx), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = '0;
    p00 = '0; p01 = '0; p10 = '0; p11 = '0;
    do_reset();

    // Directed values: max, ties, min, average extremes, mode 11 as max
    pend.push_back(mk(2'b00, 1, 2, 0, 3));
    pend.push_back(mk(2'b00, 5, 5, 5, 5));
    pend.push_back(mk(2'b01, 9, 4, 4, 7));
    pend.push_back(mk(2'b10, 255, 255, 255, 254));
    pend.push_back(mk(2'b10, 1, 1, 1, 0));
    pend.push_back(mk(2'b11, 3, 8, 8, 1));
    pend.push_back(mk(2'b01, 0, 7, 0, 0));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);

    // Backpressure: A reaches the output two cycles after acceptance, then hold three cycles
    pend.push_back(mk(2'b00, 10, 20, 30, 40));
    pend.push_back(mk(2'b01, 11, 21, 31, 41));
    pend.push_back(mk(2'b10, 12, 22, 32, 42));
    for (int i = 0; i < 12; i++) step(!(i >= 2 && i <= 4), 1'b0);

    // Overlapping windows of the 3x3 map 0,1,2 / 3,0,1 / 2,3,0
    pend.push_back(mk(2'b00, 0, 1, 3, 0));
    pend.push_back(mk(2'b00, 1, 2, 0, 1));
    pend.push_back(mk(2'b00, 3, 0, 2, 3));
    pend.push_back(mk(2'b00, 0, 1, 3, 0));
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("expq_empty_directed", 32'(expq.size()), 32'd0);

    // Reset with two windows in flight; neither may emerge
    pend.push_back(mk(2'b00, 90, 91, 92, 93));
    pend.push_back(mk(2'b00, 94, 95, 96, 97));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) step($urandom_range(0, 9) < 7, 1'b1);

    for (int i = 0; i < 20 && expq.size() > 0; i++) step(1'b1, 1'b0);
    check("drain_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/downsample.md
DOWNSAMPLE -- requirements
Module: downsample

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning pixel width in bits, treated as unsigned.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports pixel_00, pixel_01, pixel_10, pixel_11, each input, DATA_W bits, forming one 2x2 window.
- Order is top-left, top-right, bottom-left, bottom-right.
REQ-005 The block SHALL have port mode, input, 2 bits, selecting the pooling operation.
- 00 max, 01 min, 10 average, 11 treated as max.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the window and mode are valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a window this cycle.
REQ-008 The block SHALL have port max_pixel, output, DATA_W bits: the pooled result.
REQ-009 The block SHALL have port out_valid, output, 1 bit: max_pixel (and max_idx) are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port max_idx, output, 2 bits: winning position, 0=pixel_00, 1=pixel_01, 2=pixel_10, 3=pixel_11.
- This port is present only when DOWNSAMPLE_ARGMAX_EN is defined.

Function
REQ-012 A window SHALL be accepted when in_valid and in_ready are both 1; mode is sampled with the window.
REQ-013 The block SHALL be a two-stage pipeline.
- Stage 1 reduces each row: the row max/min, the row sum (DATA_W+1 bits), and the row winner index.
- Stage 2 combines the two rows.
REQ-014 The result SHALL appear with out_valid=1 exactly 2 cycles after acceptance when out_ready stays 1.
REQ-015 Sustained throughput SHALL be one window per cycle while out_ready=1.
REQ-016 Pipeline advance SHALL be global: advance = !out_valid || out_ready, and in_ready SHALL equal advance.
- When advance=0 both stages hold their contents.
- Bubbles are not collapsed.
REQ-017 While out_valid=1 and out_ready=0, max_pixel, max_idx and out_valid SHALL remain stable.
REQ-018 Max mode SHALL output the largest of the four unsigned values.
- Min mode SHALL output the smallest.
REQ-019 Average mode SHALL output floor((p00+p01+p10+p11)/4), using a DATA_W+2-bit internal sum.
- The result is bits [DATA_W+1:2] of the sum; it never overflows DATA_W.
REQ-020 Ties SHALL resolve to the lowest index, i.e. the first in order 00, 01, 10, 11.
REQ-021 In average mode, max_idx SHALL be 0.
REQ-022 When in_valid=0 while advancing, a bubble (valid=0) SHALL enter stage 1.
- Output data under out_valid=0 is don't-care, but SHALL not be X after reset.

Reset
REQ-023 On a clock edge with rst=1, both stage valid bits, out_valid, max_pixel and max_idx SHALL clear to 0.
REQ-024 rst SHALL take priority over any simultaneous handshake.
- Windows in flight when rst is asserted mid-operation are discarded and never emerge.
REQ-025 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-026 With macro DOWNSAMPLE_ARGMAX_EN defined, the max_idx port and the index-tracking logic SHALL be compiled in.
- max_idx carries the same latency and stall behaviour as max_pixel.
REQ-027 Without DOWNSAMPLE_ARGMAX_EN, max_idx and all index logic SHALL be absent.
- max_pixel behaviour is unchanged.

Verification
REQ-028 Max basic: mode=00, pixels 1,2,0,3 accepted at cycle N, out_ready=1.
- Required: out_valid=1, max_pixel=3, max_idx=3 at cycle N+2.
REQ-029 Ties and min: mode=00 with 5,5,5,5 gives max_pixel=5, max_idx=0.
- mode=01 with 9,4,4,7 gives max_pixel=4, max_idx=1.
REQ-030 Average width: mode=10 with 255,255,255,254 gives max_pixel=254.
- mode=10 with 1,1,1,0 gives max_pixel=0.
REQ-031 Backpressure: stream windows A,B,C back-to-back and hold out_ready=0 for 3 cycles when A reaches the output.
- Required: in_ready=0 during the hold and A stable.
- A, B, C are then delivered in order with none lost or duplicated.
REQ-032 Reset mid-operation: assert rst for one cycle with two windows in flight.
- Required: out_valid=0 and in_ready=1 afterwards.
- Neither window is output.
REQ-033 2x2 pooling of a 3x3 map 0,1,2 / 3,0,1 / 2,3,0 with overlapping windows in max mode.
- Required: outputs 3, 2, 3, 3 in order.
